// File: rtl/scmp_busif.sv
// scmp_busif: SC/MP-style external bus cycle sequencer with daisy-chain arbitration,
// multiplexed address phase, nhold wait extension and hold timeout.
module scmp_busif #(
    parameter int ADDR_W     = 16,
    parameter int ADS_CYC    = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_MAX   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [7:0]        wdata,
    input  logic [3:0]        flags,
    output logic              ack,
    output logic              err,
    output logic [7:0]        rdata,
    output logic [11:0]       addr,
    input  logic [7:0]        D_i,
    output logic [7:0]        D_o,
    output logic              D_oe,
    output logic              ADS_n,
    output logic              RD_n,
    output logic              WR_n,
    input  logic              nhold,
    output logic              breq,
    input  logic              enin,
    output logic              enout
);
    localparam int SW = $clog2(STROBE_CYC + 1);
    localparam int HW = HOLD_MAX > 0 ? $clog2(HOLD_MAX + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_DATA, S_DONE} state_t;

    state_t            r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic [3:0]        r_flags;
    logic [1:0]        r_acnt;
    logic [SW-1:0]     r_scnt;
    logic [HW-1:0]     r_hcnt;
    logic [3:0]        w_upper;
    logic              w_tmo;
    logic              w_start;

    assign w_upper = 4'(r_addr >> 12);
    assign w_tmo   = (HOLD_MAX > 0) && (r_hcnt == HW'(HOLD_MAX));
    assign w_start = req && (r_state == S_IDLE || r_state == S_DONE);
    assign enout   = enin & ~breq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_flags <= '0;
            r_acnt  <= '0;
            r_scnt  <= '0;
            r_hcnt  <= '0;
            ack     <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            addr    <= '0;
            D_o     <= '0;
            D_oe    <= 1'b0;
            ADS_n   <= 1'b1;
            RD_n    <= 1'b1;
            WR_n    <= 1'b1;
            breq    <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            if (w_start) begin
                r_we    <= we;
                r_addr  <= addr_in;
                r_wdata <= wdata;
                r_flags <= flags;
            end
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_state <= S_REQ;
                        breq    <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (enin) begin
                        r_state <= S_ADDR;
                        r_acnt  <= '0;
                        ADS_n   <= 1'b0;
                        addr    <= r_addr[11:0];
                        D_o     <= {r_flags, w_upper};
                        D_oe    <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (r_acnt == 2'(ADS_CYC - 1)) begin
                        r_state <= S_DATA;
                        r_scnt  <= '0;
                        r_hcnt  <= '0;
                        ADS_n   <= 1'b1;
                        RD_n    <= r_we;
                        WR_n    <= ~r_we;
                        D_o     <= r_we ? r_wdata : 8'h00;
                        D_oe    <= r_we;
                    end else begin
                        r_acnt <= r_acnt + 2'd1;
                    end
                end
                S_DATA: begin
                    // nhold has priority over the timeout on the same edge
                    if (r_scnt != SW'(STROBE_CYC - 1)) begin
                        r_scnt <= r_scnt + 1'b1;
                    end else if (nhold || w_tmo) begin
                        r_state <= S_DONE;
                        RD_n    <= 1'b1;
                        WR_n    <= 1'b1;
                        ack     <= 1'b1;
                        err     <= ~nhold;
                        if (!r_we) rdata <= nhold ? D_i : 8'hFF;
                    end else if (r_hcnt != '1) begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    D_o     <= 8'h00;
                    D_oe    <= 1'b0;
                    r_state <= req ? S_REQ : S_IDLE;
                    breq    <= req;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scmp_busif.sv
// tb_scmp_busif: directed bus-cycle vectors for scmp_busif (HOLD_MAX=4 so the timeout is reachable).
module tb_scmp_busif;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr_in = '0;
    logic [7:0]  wdata = '0;
    logic [3:0]  flags = '0;
    logic        ack, err;
    logic [7:0]  rdata;
    logic [11:0] addr;
    logic [7:0]  D_i = '0;
    logic [7:0]  D_o;
    logic        D_oe, ADS_n, RD_n, WR_n;
    logic        nhold = 1'b1;
    logic        breq;
    logic        enin = 1'b1;
    logic        enout;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_ack = 0;
    int          a0;

    scmp_busif #(.HOLD_MAX(4)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr_in(addr_in), .wdata(wdata),
        .flags(flags), .ack(ack), .err(err), .rdata(rdata), .addr(addr), .D_i(D_i),
        .D_o(D_o), .D_oe(D_oe), .ADS_n(ADS_n), .RD_n(RD_n), .WR_n(WR_n), .nhold(nhold),
        .breq(breq), .enin(enin), .enout(enout)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (ack) n_ack++;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input logic w, input logic [15:0] a, input logic [3:0] f, input logic [7:0] d);
        req = 1'b1; we = w; addr_in = a; flags = f; wdata = d;
    endtask

    initial begin
        tick(2);
        chk("rst_strobes", {13'd0, ADS_n, RD_n, WR_n}, 16'h0007);
        chk("rst_drive", {D_oe, breq, ack, err, 4'd0, D_o}, 16'h0000);
        chk("rst_rdata_addr", {rdata, addr[7:0]}, 16'h0000);
        chk("rst_addr_hi", {12'd0, addr[11:8]}, 16'h0000);
        rst = 1'b0;
        tick();
        chk("idle_enout", {15'd0, enout}, 16'h0001);

        // basic read
        a0 = n_ack;
        start(1'b0, 16'hA123, 4'b0001, 8'h00); D_i = 8'h5A;
        tick();
        chk("rd_req_breq", {14'd0, breq, enout}, 16'h0002);
        chk("rd_req_ads", {15'd0, ADS_n}, 16'h0001);
        tick();
        chk("rd_addr_ads", {13'd0, ADS_n, RD_n, D_oe}, 16'h0003);
        chk("rd_addr_pins", {4'd0, addr}, 16'h0123);
        chk("rd_addr_do", {8'd0, D_o}, 16'h001A);
        tick();
        chk("rd_data1", {12'd0, ADS_n, RD_n, WR_n, D_oe}, 16'h000A);
        tick();
        chk("rd_data2", {13'd0, RD_n, ack, D_oe}, 16'h0000);
        tick();
        chk("rd_done", {13'd0, RD_n, ack, err}, 16'h0006);
        chk("rd_rdata", {8'd0, rdata}, 16'h005A);
        req = 1'b0;
        tick();
        chk("rd_idle", {14'd0, ack, breq}, 16'h0000);
        chk("rd_hold_rdata", {8'd0, rdata}, 16'h005A);
        chk("rd_nack", n_ack - a0, 1);

        // write with nhold stretching three cycles past the strobe minimum
        a0 = n_ack;
        start(1'b1, 16'h0456, 4'hA, 8'hC3);
        tick(2);
        chk("wr_addr_do", {8'd0, D_o}, 16'h00A0);
        chk("wr_addr_pins", {4'd0, addr}, 16'h0456);
        tick();
        nhold = 1'b0;
        chk("wr_data", {13'd0, RD_n, WR_n, D_oe}, 16'h0005);
        chk("wr_data_do", {8'd0, D_o}, 16'h00C3);
        for (int i = 2; i <= 5; i++) begin
            tick();
            chk($sformatf("wr_low%0d", i), {14'd0, WR_n, ack}, 16'h0000);
        end
        nhold = 1'b1;
        tick();
        chk("wr_done", {12'd0, WR_n, ack, err, D_oe}, 16'h000D);
        chk("wr_done_do", {8'd0, D_o}, 16'h00C3);
        req = 1'b0;
        tick();
        chk("wr_after", {14'd0, ack, D_oe}, 16'h0000);
        chk("wr_nack", n_ack - a0, 1);

        // hold timeout
        a0 = n_ack;
        start(1'b0, 16'h0789, 4'h0, 8'h00); D_i = 8'h5A; nhold = 1'b0;
        tick(3);
        for (int i = 1; i <= 6; i++) begin
            chk($sformatf("to_low%0d", i), {14'd0, RD_n, ack}, 16'h0000);
            tick();
        end
        chk("to_done", {13'd0, RD_n, ack, err}, 16'h0007);
        chk("to_rdata", {8'd0, rdata}, 16'h00FF);
        req = 1'b0; nhold = 1'b1;
        tick();
        chk("to_after", {14'd0, ack, err}, 16'h0000);
        chk("to_nack", n_ack - a0, 1);

        // delayed grant, then grant dropped mid-cycle
        a0 = n_ack;
        enin = 1'b0;
        start(1'b0, 16'h0BCD, 4'h0, 8'h00); D_i = 8'h3C;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("gr_wait%0d", i), {11'd0, breq, enout, ADS_n, RD_n, WR_n}, 16'h0017);
            tick();
        end
        enin = 1'b1;
        chk("gr_enout_own", {15'd0, enout}, 16'h0000);
        tick();
        chk("gr_ads", {15'd0, ADS_n}, 16'h0000);
        chk("gr_addr", {4'd0, addr}, 16'h0BCD);
        enin = 1'b0;
        tick(3);
        chk("gr_done", {14'd0, ack, err}, 16'h0002);
        chk("gr_rdata", {8'd0, rdata}, 16'h003C);
        req = 1'b0; enin = 1'b1;
        tick();
        chk("gr_nack", n_ack - a0, 1);

        // back-to-back: read then write with req held across ack
        a0 = n_ack;
        start(1'b0, 16'h1111, 4'h0, 8'h00); D_i = 8'h77;
        tick(2);
        chk("bb1_addr", {4'd0, addr}, 16'h0111);
        chk("bb1_do", {8'd0, D_o}, 16'h0001);
        start(1'b1, 16'h2222, 4'h0, 8'h99);
        tick(3);
        chk("bb1_done", {14'd0, ack, err}, 16'h0002);
        chk("bb1_rdata", {8'd0, rdata}, 16'h0077);
        tick();
        chk("bb_req", {13'd0, breq, ack, ADS_n}, 16'h0005);
        req = 1'b0;
        tick();
        chk("bb2_ads", {15'd0, ADS_n}, 16'h0000);
        chk("bb2_addr", {4'd0, addr}, 16'h0222);
        chk("bb2_do", {8'd0, D_o}, 16'h0002);
        tick();
        chk("bb2_wr", {14'd0, WR_n, RD_n}, 16'h0001);
        chk("bb2_wdata", {8'd0, D_o}, 16'h0099);
        tick(2);
        chk("bb2_done", {14'd0, ack, err}, 16'h0002);
        chk("bb2_rdata_kept", {8'd0, rdata}, 16'h0077);
        tick();
        chk("bb_nack", n_ack - a0, 2);

        // asynchronous reset mid-DATA of a write
        a0 = n_ack;
        start(1'b1, 16'h0333, 4'h0, 8'hE7);
        tick(3);
        chk("ar_data", {14'd0, WR_n, D_oe}, 16'h0001);
        #2;
        rst = 1'b1; req = 1'b0;
        #1;
        chk("ar_release", {12'd0, WR_n, D_oe, breq, ack}, 16'h0008);
        chk("ar_addr", {4'd0, addr}, 16'h0000);
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("ar_idle%0d", i), {11'd0, ack, breq, ADS_n, RD_n, WR_n}, 16'h0007);
        end
        chk("ar_nack", n_ack - a0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/scmp_busif.md
SCMP_BUSIF -- requirements
Module: scmp_busif

Interface
REQ-001 Parameter ADDR_W, 16, total address width; legal range 12..16; bits above 11 are multiplexed onto D_o[ADDR_W-13:0] during the address phase.
REQ-002 Parameter ADS_CYC, 1, address-strobe length in cycles; legal range 1..4.
REQ-003 Parameter STROBE_CYC, 2, minimum RD_n/WR_n low time in cycles; legal range 1..15.
REQ-004 Parameter HOLD_MAX, 255, maximum nhold extension in cycles before timeout; 0 disables the timeout.
REQ-005 Ports, in order:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  core bus request, level; held until ack.
- we  in  1  1 = write, 0 = read.
- addr_in  in  ADDR_W  cycle address.
- wdata  in  8  write data.
- flags  in  4  {F_H,F_D,F_I,F_R} status for the address phase.
- ack  out  1  one-cycle completion pulse.
- err  out  1  valid with ack; 1 = hold timeout.
- rdata  out  8  read data; valid from ack, held until the next ack.
- addr  out  12  external address pins.
- D_i  in  8  external data in.
- D_o  out  8  external data out.
- D_oe  out  1  D_o drive enable.
- ADS_n / RD_n / WR_n  out  1 each  active-low strobes.
- nhold  in  1  active-low wait request from memory.
- breq  out  1  bus request to the daisy chain.
- enin  in  1  bus grant from upstream.
- enout  out  1  bus grant to downstream.
REQ-006 Inputs req, we, addr_in, wdata and flags SHALL be sampled once, when the block leaves IDLE, and latched for the whole cycle.

Function
REQ-007 The FSM SHALL have the states IDLE, REQ, ADDR, DATA and DONE, one-hot or binary.
REQ-008 IDLE: if req=1, go to REQ and latch the inputs; otherwise stay in IDLE.
REQ-009 REQ: breq=1; go to ADDR on the first edge with enin=1; wait indefinitely otherwise.
REQ-010 ADDR: ADS_n=0 for exactly ADS_CYC cycles, then go to DATA.
REQ-011 ADDR drive values: addr=latched addr[11:0]; D_oe=1; D_o={flags, upper 4 bits}, where the upper bits are addr[ADDR_W-1:12] zero-extended to 4 bits.
REQ-012 DATA: RD_n=0 (read) or WR_n=0 (write), never both; for a write, D_o=wdata and D_oe=1; for a read, D_oe=0.
REQ-013 A DATA stay SHALL last STROBE_CYC cycles, counted by a strobe counter that resets on DATA entry.
REQ-014 Once the strobe count is reached, each edge with nhold=0 SHALL keep the block in DATA and increment a hold counter; the first edge with nhold=1 SHALL exit to DONE.
REQ-015 If HOLD_MAX>0 and the hold counter reaches HOLD_MAX, the block SHALL exit to DONE with the error flag set.
REQ-016 A read SHALL capture D_i into rdata on the DATA exit edge; on timeout, rdata=8'hFF.
REQ-017 DONE lasts one cycle:
- ack=1, err=error flag.
- Strobes high.
- A write keeps D_o/D_oe for one cycle of data hold.
- breq stays 1.
- Next state: REQ if req=1 (back-to-back, new inputs latched), otherwise IDLE.
REQ-018 addr SHALL hold its last value outside ADDR/DATA.
REQ-019 enout SHALL equal enin & ~breq, combinationally.
REQ-020 A drop of enin after ADDR entry SHALL NOT abort the cycle.
REQ-021 Latency with enin=1, nhold=1 and default parameters: req sampled at edge 0 -> ack high in the cycle after edge 4, i.e. 2+ADS_CYC+STROBE_CYC cycles.
REQ-022 The strobe and hold counters SHALL be sized to hold STROBE_CYC and HOLD_MAX without wrap; the hold counter saturates when HOLD_MAX=0.

Reset
REQ-023 rst=1 SHALL force, asynchronously, regardless of state:
- state=IDLE.
- ADS_n=RD_n=WR_n=1.
- D_oe=0, D_o=0, breq=0, ack=0, err=0.
- rdata=0, addr=0, both counters=0.
REQ-024 A reset during ADDR or DATA SHALL release all strobes in the same cycle, and after reset the cycle SHALL NOT be resumed or acked.

Verification
REQ-025 Read, defaults, enin=1, nhold=1, addr_in=16'hA123, flags=4'b0001, D_i=8'h5A -> ADS_n low 1 cycle with addr=12'h123 and D_o=8'h1A; RD_n low 2 cycles; ack pulse at cycle 5 with rdata=8'h5A, err=0.
REQ-026 Write, wdata=8'hC3, nhold=0 for 3 cycles after the strobe minimum -> WR_n low 5 cycles, D_o=8'hC3 through DONE; single ack.
REQ-027 HOLD_MAX=4, read, nhold stuck 0 -> RD_n released after 2+4 cycles; ack with err=1 and rdata=8'hFF.
REQ-028 enin=0 for 10 cycles after req -> breq=1 and enout=0 throughout with no strobes; ADDR starts the edge after enin=1.
REQ-029 req held high across ack, with a new addr_in presented before ack -> REQ re-entered directly, second cycle uses the new address, two ack pulses.
REQ-030 rst asserted mid-DATA of a write -> WR_n, D_oe and breq deassert immediately; no ack; after rst release with req=0, the block stays idle.
